// File: rtl/inv_subbytes_seq_if.sv
// Interface bundling the handshake, data, abort and status signals of
// inv_subbytes_seq.
//   abort     : synchronous abort request (master -> slave)
//   in_valid  : in_data valid (master -> slave)
//   in_ready  : sequencer can take a block (slave -> master)
//   in_data   : 128-bit state block, byte 0 in bits [127:120]
//   out_valid : out_data valid (slave -> master)
//   out_ready : consumer takes out_data (master -> slave)
//   out_data  : inverse-substituted block, same byte order
//   busy      : block in flight or waiting to be taken (slave -> master)
interface inv_subbytes_seq_if;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_subbytes_seq.sv
// AES inverse SubBytes sequencer. Takes one 128-bit state block, pushes it
// through NUM_SBOX inverse S-boxes, NUM_SBOX bytes per clock, and returns the
// substituted block. Trades S-box count against latency (16/NUM_SBOX cycles).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : inv_subbytes_seq_if.slave (abort, in/out handshakes, busy)

// Combinational AES inverse S-box (FIPS-197 table).
// Ports: a = input byte, y = substituted byte.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] INV_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = INV_TAB[a];
endmodule

// state | meaning
// IDLE  | waiting for a block; in_ready high
// BUSY  | substituting NUM_SBOX bytes per cycle, cnt selects the byte group
// DONE  | result held on out_data with out_valid high until taken
module inv_subbytes_seq #(
  parameter int NUM_SBOX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  inv_subbytes_seq_if.slave  bus
);
  localparam int NUM_STEPS = 16 / NUM_SBOX;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_STEPS - 1);

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
      NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
    $error("inv_subbytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [127:0]     work, work_nxt, work_sub;
  logic [3:0]       base;
  logic [7:0]       sbox_in  [NUM_SBOX];
  logic [7:0]       sbox_out [NUM_SBOX];

  // First byte index of the group handled this cycle; never exceeds 15.
  assign base = 4'(int'(cnt) * NUM_SBOX);

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_sbox
    logic [3:0] idx;
    assign idx        = base + 4'(j);
    assign sbox_in[j] = work[8*(15 - int'(idx)) +: 8];
    inv_sbox u_inv_sbox (.a(sbox_in[j]), .y(sbox_out[j]));
  end

  // In-place writeback: only the selected group changes.
  always_comb begin
    work_sub = work;
    for (int j = 0; j < NUM_SBOX; j++) begin
      work_sub[8*(15 - int'(base) - j) +: 8] = sbox_out[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      work  <= work_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
          work_nxt  = bus.in_data;
        end
      end
      BUSY: begin
        work_nxt = work_sub;
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything, including a load in IDLE; the work
    // register keeps whatever it held.
    if (bus.abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      work_nxt  = work;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = (state == DONE) ? work : '0;
endmodule
